// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, direct-mapped one-word-line I-cache,
// miss refill over a req/done memory handshake, registered bundle to decode.
module if_stage #(
  parameter int          ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        id_stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        dbg_fetch_o
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  // Memory handshake: mem_req_o rises with mem_addr_o and both stay put
  // until the one-cycle mem_done_i pulse; there is no way to abort a request.
  typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_mem_req, w_mem_req_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_pc_o, w_pc_o_nxt;
  logic [31:0] r_inst_o, w_inst_o_nxt;
  logic        r_valid, w_valid_nxt;

  logic [31:0]      r_data [LINES];
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [LINES-1:0] r_line_valid;

  logic [ICACHE_IDX_W-1:0] w_idx, w_fill_idx;
  logic [TAG_W-1:0]        w_tag, w_fill_tag;
  logic                    w_hit, w_fill, w_hold;

  assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag      = r_pc[31:ICACHE_IDX_W+2];
  assign w_hit      = r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_idx = r_mem_addr[ICACHE_IDX_W+1:2];
  assign w_fill_tag = r_mem_addr[31:ICACHE_IDX_W+2];
  assign w_fill     = rdy && (r_state == S_FETCH) && mem_done_i;
  assign w_hold     = id_stall_i && r_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_pc_o_nxt     = r_pc_o;
    w_inst_o_nxt   = r_inst_o;
    w_valid_nxt    = r_valid;
    case (r_state)
      S_IDLE: begin
        if (jump_i) begin
          w_pc_nxt    = jump_addr_i;
          w_valid_nxt = 1'b0;
        end else if (w_hold) begin
          w_valid_nxt = r_valid;
        end else if (w_hit) begin
          w_pc_o_nxt   = r_pc;
          w_inst_o_nxt = r_data[w_idx];
          w_valid_nxt  = 1'b1;
          w_pc_nxt     = r_pc + 32'd4;
        end else begin
          w_valid_nxt    = 1'b0;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_pc;
          w_state_nxt    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!w_hold) w_valid_nxt = 1'b0;
        // A redirect retargets the PC now; the in-flight fill still lands.
        if (jump_i) w_pc_nxt = jump_addr_i;
        if (mem_done_i) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_pc_o     <= 32'h0;
      r_inst_o   <= 32'h0;
      r_valid    <= 1'b0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_pc_o     <= w_pc_o_nxt;
      r_inst_o   <= w_inst_o_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_line_valid <= '0;
    else if (w_fill) r_line_valid[w_fill_idx] <= 1'b1;
  end

  // Data and tag storage need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fill_idx] <= mem_data_i;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  assign pc_o        = r_pc_o;
  assign inst_o      = r_inst_o;
  assign valid_o     = r_valid;
  assign dbg_fetch_o = (r_state == S_FETCH);

endmodule

// File: tb/tb_if_stage.sv
// Directed cycle-by-cycle vectors for if_stage: cold start, warm loop, stall,
// redirect mid-miss, aliasing, rdy freeze, reset mid-fetch and PC wrap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        id_stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        dbg_fetch_o;

  if_stage #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .id_stall_i(id_stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_done_i(mem_done_i), .mem_data_i(mem_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o), .dbg_fetch_o(dbg_fetch_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  localparam logic [31:0] I0   = 32'h00100093;
  localparam logic [31:0] I4   = 32'h00200113;
  localparam logic [31:0] I8   = 32'h00300193;
  localparam logic [31:0] I12  = 32'h00400213;
  localparam logic [31:0] I40  = 32'h00500293;
  localparam logic [31:0] I20  = 32'h00600313;
  localparam logic [31:0] I100 = 32'h00700393;
  localparam logic [31:0] I80  = 32'h00800413;
  localparam logic [31:0] IF   = 32'h00900493;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;
  localparam logic [31:0] TOP  = 32'hFFFFFFFC;

  typedef struct {
    logic        rdy, stall, jump;
    logic [31:0] jaddr;
    logic        done;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr, pc, inst;
    logic        valid;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   split;

  task automatic row(input logic r, input logic s, input logic j, input logic [31:0] ja,
                     input logic d, input logic [31:0] dt, input logic rq,
                     input logic [31:0] ad, input logic [31:0] pc, input logic [31:0] in,
                     input logic v);
    vec_t t;
    t.rdy = r; t.stall = s; t.jump = j; t.jaddr = ja; t.done = d; t.data = dt;
    t.req = rq; t.addr = ad; t.pc = pc; t.inst = in; t.valid = v;
    tbl.push_back(t);
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic rq, input logic [31:0] ad,
                               input logic [31:0] pc, input logic [31:0] in, input logic v);
    chk({tag, ".req"},   {31'b0, mem_req_o}, {31'b0, rq});
    chk({tag, ".addr"},  mem_addr_o, ad);
    chk({tag, ".pc"},    pc_o, pc);
    chk({tag, ".inst"},  inst_o, in);
    chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
  endtask

  // driver: inputs settle mid-cycle, outputs sampled 1 time unit after the edge
  task automatic run_row(input int i);
    rdy         = tbl[i].rdy;
    id_stall_i  = tbl[i].stall;
    jump_i      = tbl[i].jump;
    jump_addr_i = tbl[i].jaddr;
    mem_done_i  = tbl[i].done;
    mem_data_i  = tbl[i].data;
    @(posedge clk);
    #1;
    check_outputs($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].pc,
                  tbl[i].inst, tbl[i].valid);
  endtask

  initial begin
    // cold start: miss at 0, memory answers on the third cycle
    row(1,0,0,0,0,0,    1,0,0,0,0);
    row(1,0,0,0,0,0,    1,0,0,0,0);
    row(1,0,0,0,0,0,    1,0,0,0,0);
    row(1,0,0,0,1,I0,   0,0,0,0,0);
    row(1,0,0,0,0,0,    0,0,0,I0,1);
    row(1,0,0,0,0,0,    1,4,0,I0,0);
    row(1,0,0,0,1,I4,   0,4,0,I0,0);
    row(1,0,0,0,0,0,    0,4,4,I4,1);
    row(1,0,0,0,0,0,    1,8,4,I4,0);
    row(1,0,0,0,1,I8,   0,8,4,I4,0);
    row(1,0,0,0,0,0,    0,8,8,I8,1);
    row(1,0,0,0,0,0,    1,12,8,I8,0);
    row(1,0,0,0,1,I12,  0,12,8,I8,0);
    row(1,0,0,0,0,0,    0,12,12,I12,1);
    // warm loop, stray done in IDLE ignored
    row(1,0,1,0,0,0,    0,12,12,I12,0);
    row(1,0,0,0,0,0,    0,12,0,I0,1);
    row(1,0,0,0,1,JUNK, 0,12,4,I4,1);
    row(1,0,0,0,0,0,    0,12,8,I8,1);
    row(1,0,0,0,0,0,    0,12,12,I12,1);
    // stall at pc_o=8
    row(1,0,1,0,0,0,    0,12,12,I12,0);
    row(1,0,0,0,0,0,    0,12,0,I0,1);
    row(1,0,0,0,0,0,    0,12,4,I4,1);
    row(1,0,0,0,0,0,    0,12,8,I8,1);
    row(1,1,0,0,0,0,    0,12,8,I8,1);
    row(1,1,0,0,0,0,    0,12,8,I8,1);
    row(1,0,0,0,0,0,    0,12,12,I12,1);
    // stall + jump to 0x40
    row(1,1,1,32'h40,0,0,   0,12,12,I12,0);
    row(1,0,0,0,0,0,        1,32'h40,12,I12,0);
    row(1,0,0,0,1,I40,      0,32'h40,12,I12,0);
    row(1,0,0,0,0,0,        0,32'h40,32'h40,I40,1);
    // redirect to 0x100 while fetching 0x20
    row(1,0,1,32'h20,0,0,   0,32'h40,32'h40,I40,0);
    row(1,0,0,0,0,0,        1,32'h20,32'h40,I40,0);
    row(1,0,1,32'h100,0,0,  1,32'h20,32'h40,I40,0);
    row(1,0,0,0,1,I20,      0,32'h20,32'h40,I40,0);
    row(1,0,0,0,0,0,        1,32'h100,32'h40,I40,0);
    row(1,0,0,0,1,I100,     0,32'h100,32'h40,I40,0);
    row(1,0,0,0,0,0,        0,32'h100,32'h100,I100,1);
    row(1,0,1,32'h20,0,0,   0,32'h100,32'h100,I100,0);
    row(1,0,0,0,0,0,        0,32'h100,32'h20,I20,1);
    // aliasing: 0x0 and 0x100 share index 0
    row(1,0,1,0,0,0,        0,32'h100,32'h20,I20,0);
    row(1,0,0,0,0,0,        1,0,32'h20,I20,0);
    row(1,0,0,0,1,I0,       0,0,32'h20,I20,0);
    row(1,0,0,0,0,0,        0,0,0,I0,1);
    row(1,0,1,32'h100,0,0,  0,0,0,I0,0);
    row(1,0,0,0,0,0,        1,32'h100,0,I0,0);
    row(1,0,0,0,1,I100,     0,32'h100,0,I0,0);
    row(1,0,0,0,0,0,        0,32'h100,32'h100,I100,1);
    // rdy=0 for 5 cycles mid-FETCH, done pulse lost while frozen
    row(1,0,1,32'h80,0,0,   0,32'h100,32'h100,I100,0);
    row(1,0,0,0,0,0,        1,32'h80,32'h100,I100,0);
    row(0,0,0,0,0,0,        1,32'h80,32'h100,I100,0);
    row(0,0,0,0,0,0,        1,32'h80,32'h100,I100,0);
    row(0,0,0,0,1,JUNK,     1,32'h80,32'h100,I100,0);
    row(0,0,0,0,0,0,        1,32'h80,32'h100,I100,0);
    row(0,0,0,0,0,0,        1,32'h80,32'h100,I100,0);
    row(1,0,0,0,0,0,        1,32'h80,32'h100,I100,0);
    row(1,0,0,0,1,I80,      0,32'h80,32'h100,I100,0);
    row(1,0,0,0,0,0,        0,32'h80,32'h80,I80,1);
    row(0,0,0,0,0,0,        0,32'h80,32'h80,I80,1);
    row(1,0,0,0,0,0,        1,32'h84,32'h80,I80,0);
    split = tbl.size();
    // after reset mid-fetch: late done ignored, cache cold, then PC wrap
    row(1,0,0,0,1,JUNK,     1,0,0,0,0);
    row(1,0,0,0,1,I0,       0,0,0,0,0);
    row(1,0,0,0,0,0,        0,0,0,I0,1);
    row(1,0,1,TOP,0,0,      0,0,0,I0,0);
    row(1,0,0,0,0,0,        1,TOP,0,I0,0);
    row(1,0,0,0,1,IF,       0,TOP,0,I0,0);
    row(1,0,0,0,0,0,        0,TOP,TOP,IF,1);
    row(1,0,0,0,0,0,        0,TOP,0,I0,1);

    // initial reset
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0, 0, 0);
    chk("reset.fetch_state", {31'b0, dbg_fetch_o}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < split; i++) run_row(i);

    // asynchronous reset while a fetch is outstanding
    chk("pre_reset.fetch_state", {31'b0, dbg_fetch_o}, 32'h1);
    rst = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = split; i < tbl.size(); i++) run_row(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
